// File: rtl/procesador_pkg.sv
// Shared opcode constants, tag bit positions and the status-tag layout for the procesador datapath.
// Latency: none (declarations only).
// Backpressure: not applicable.
package procesador_pkg;

    // Function unit operation select (G_sel)
    localparam logic [3:0] G_PASS_A     = 4'b0000;
    localparam logic [3:0] G_INC_A      = 4'b0001;
    localparam logic [3:0] G_ADD        = 4'b0010;
    localparam logic [3:0] G_ADD_INC    = 4'b0011;
    localparam logic [3:0] G_ADD_NOT_B  = 4'b0100;
    localparam logic [3:0] G_SUB        = 4'b0101;
    localparam logic [3:0] G_DEC_A      = 4'b0110;
    localparam logic [3:0] G_PASS_A_ALT = 4'b0111;
    localparam logic [3:0] G_AND        = 4'b1000;
    localparam logic [3:0] G_OR         = 4'b1001;
    localparam logic [3:0] G_XOR        = 4'b1010;
    localparam logic [3:0] G_NOT_A      = 4'b1011;
    localparam logic [3:0] G_PASS_B     = 4'b1100;
    localparam logic [3:0] G_NOT_B      = 4'b1101;
    localparam logic [3:0] G_ZERO       = 4'b1110;
    localparam logic [3:0] G_ONES       = 4'b1111;

    // Shifter operation select (H_sel)
    localparam logic [1:0] H_PASS_B = 2'b00;
    localparam logic [1:0] H_SHR    = 2'b01;
    localparam logic [1:0] H_SHL    = 2'b10;
    localparam logic [1:0] H_ZERO   = 2'b11;

    // Tag bit indices within Tags
    localparam int TAG_V = 3;
    localparam int TAG_C = 2;
    localparam int TAG_N = 1;
    localparam int TAG_Z = 0;

    // Packed so that v lands on bit 3 and z on bit 0
    typedef struct packed {
        logic v;
        logic c;
        logic n;
        logic z;
    } tags_t;

endpackage

// File: rtl/procesador_unidad_funcional.sv
// Function unit: ALU, shifter, F select and status tags.
// Latency: purely combinational, F and tags follow a/b/selects in the same cycle.
// Backpressure: none; always accepts operands.
//   a, b         : A and B bus operands
//   g_sel, h_sel : ALU and shifter operation selects
//   mf_sel       : 0 = ALU result, 1 = shifter result
//   f, tags      : function output and {V,C,N,Z}
module unidad_funcional
    import procesador_pkg::*;
#(
    parameter int m = 8
) (
    input  logic [m-1:0] a,
    input  logic [m-1:0] b,
    input  logic [3:0]   g_sel,
    input  logic [1:0]   h_sel,
    input  logic         mf_sel,
    output logic [m-1:0] f,
    output logic [3:0]   tags
);

    logic [m-1:0] addend;
    logic         carry_in;
    logic [m:0]   sum;
    logic [m-1:0] alu_res;
    logic         alu_c;
    logic         alu_v;
    logic [m-1:0] shift_res;
    tags_t        tag_s;

    // Second addend and carry-in for the arithmetic half of the opcode space
    always_comb begin
        addend   = '0;
        carry_in = 1'b0;
        case (g_sel)
            G_INC_A:     carry_in = 1'b1;
            G_ADD:       addend   = b;
            G_ADD_INC: begin
                addend   = b;
                carry_in = 1'b1;
            end
            G_ADD_NOT_B: addend   = ~b;
            G_SUB: begin
                addend   = ~b;
                carry_in = 1'b1;
            end
            G_DEC_A:     addend   = '1;
            default: begin
                addend   = '0;
                carry_in = 1'b0;
            end
        endcase
    end

    assign sum = {1'b0, a} + {1'b0, addend} + {{m{1'b0}}, carry_in};

    always_comb begin
        alu_res = sum[m-1:0];
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        if (g_sel[3] == 1'b0) begin
            alu_c = sum[m];
            // Signed overflow: equal addend signs, result sign differs
            alu_v = (a[m-1] == addend[m-1]) && (sum[m-1] != a[m-1]);
        end else begin
            case (g_sel)
                G_AND:   alu_res = a & b;
                G_OR:    alu_res = a | b;
                G_XOR:   alu_res = a ^ b;
                G_NOT_A: alu_res = ~a;
                G_PASS_B: alu_res = b;
                G_NOT_B: alu_res = ~b;
                G_ZERO:  alu_res = '0;
                default: alu_res = '1;
            endcase
        end
    end

    always_comb begin
        case (h_sel)
            H_PASS_B: shift_res = b;
            H_SHR:    shift_res = {1'b0, b[m-1:1]};
            H_SHL:    shift_res = {b[m-2:0], 1'b0};
            default:  shift_res = '0;
        endcase
    end

    assign f = mf_sel ? shift_res : alu_res;

    // Carry and overflow only meaningful for the ALU path
    assign tag_s.v = mf_sel ? 1'b0 : alu_v;
    assign tag_s.c = mf_sel ? 1'b0 : alu_c;
    assign tag_s.n = f[m-1];
    assign tag_s.z = (f == '0);
    assign tags    = tag_s;

endmodule

// File: rtl/procesador.sv
// Four-register datapath: register file, A/B bus muxes and write-back around the function unit.
// Latency: outputs combinational; write-back lands on the next rising clock edge.
// Backpressure: none; a write happens every edge where Load_en[D_sel] is set.
//   clock, reset         : rising-edge clock, async active-high reset
//   A_sel, B_sel, D_sel  : A read, B read and write-back register indices
//   Cons_IN, Data_IN     : constant operand and external write-back data
//   G_sel, H_sel         : ALU / shifter op selects
//   MB_sel, MF_sel, MD_sel: B source, F source, write-back source
//   Load_en              : per-register write enable
//   Tags, Address_out, Data_out : {V,C,N,Z}, A bus, B bus
module procesador
    import procesador_pkg::*;
#(
    parameter int m = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [1:0]   A_sel,
    input  logic [1:0]   B_sel,
    input  logic [1:0]   D_sel,
    input  logic [m-1:0] Cons_IN,
    input  logic [m-1:0] Data_IN,
    input  logic [3:0]   G_sel,
    input  logic [1:0]   H_sel,
    input  logic         MB_sel,
    input  logic         MF_sel,
    input  logic         MD_sel,
    input  logic [3:0]   Load_en,
    output logic [3:0]   Tags,
    output logic [m-1:0] Address_out,
    output logic [m-1:0] Data_out
);

    logic [m-1:0] regs [4];
    logic [m-1:0] a_bus;
    logic [m-1:0] b_bus;
    logic [m-1:0] f;
    logic [m-1:0] d_bus;

    assign a_bus       = regs[A_sel];
    assign b_bus       = MB_sel ? Cons_IN : regs[B_sel];
    assign Address_out = a_bus;
    assign Data_out    = b_bus;

    unidad_funcional #(
        .m(m)
    ) u_unidad_funcional (
        .a      (a_bus),
        .b      (b_bus),
        .g_sel  (G_sel),
        .h_sel  (H_sel),
        .mf_sel (MF_sel),
        .f      (f),
        .tags   (Tags)
    );

    assign d_bus = MD_sel ? Data_IN : f;

    // Only the enable bit of the addressed register matters; reads see the
    // old value until the edge since there is no bypass path.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else if (Load_en[D_sel]) begin
            regs[D_sel] <= d_bus;
        end
    end

endmodule

// File: tb/tb_procesador.sv
module tb_procesador;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] A_sel, B_sel, D_sel;
    logic [7:0] Cons_IN, Data_IN;
    logic [3:0] G_sel;
    logic [1:0] H_sel;
    logic       MB_sel, MF_sel, MD_sel;
    logic [3:0] Load_en;
    logic [3:0] Tags;
    logic [7:0] Address_out, Data_out;

    int errors = 0;
    int checks = 0;

    procesador #(.m(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .A_sel       (A_sel),
        .B_sel       (B_sel),
        .D_sel       (D_sel),
        .Cons_IN     (Cons_IN),
        .Data_IN     (Data_IN),
        .G_sel       (G_sel),
        .H_sel       (H_sel),
        .MB_sel      (MB_sel),
        .MF_sel      (MF_sel),
        .MD_sel      (MD_sel),
        .Load_en     (Load_en),
        .Tags        (Tags),
        .Address_out (Address_out),
        .Data_out    (Data_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past one rising edge, leaving time away from the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Let combinational outputs settle after an input change
    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1;
        A_sel = 2'd0; B_sel = 2'd0; D_sel = 2'd0;
        Cons_IN = 8'h00; Data_IN = 8'h00;
        G_sel = 4'b0000; H_sel = 2'b00;
        MB_sel = 1'b0; MF_sel = 1'b0; MD_sel = 1'b0;
        Load_en = 4'b0000;
        #12;
        check("reset_addr", Address_out, 8'h00);
        check("reset_data", Data_out, 8'h00);
        check("reset_tags", {4'h0, Tags}, 8'h01);
        reset = 1'b0;
        tick();

        // Constant load into R1
        MB_sel = 1'b1; Cons_IN = 8'h05; G_sel = 4'b1100; MF_sel = 1'b0; MD_sel = 1'b0;
        D_sel = 2'd1; Load_en = 4'b0010;
        tick();
        Load_en = 4'b0000; A_sel = 2'd1;
        settle();
        check("const_readback", Address_out, 8'h05);
        check("b_bus_const", Data_out, 8'h05);

        // Data_IN load into R2, then N-only tags on pass-A
        MD_sel = 1'b1; Data_IN = 8'h80; D_sel = 2'd2; Load_en = 4'b0100;
        tick();
        Load_en = 4'b0000; MD_sel = 1'b0; A_sel = 2'd2; MF_sel = 1'b0; G_sel = 4'b0000;
        settle();
        check("datain_readback", Address_out, 8'h80);
        check("pass_a_tags", {4'h0, Tags}, 8'h02);

        // 0x80 + 0x80 overflows to zero with carry
        B_sel = 2'd2; MB_sel = 1'b0; G_sel = 4'b0010;
        settle();
        check("add_ovf_tags", {4'h0, Tags}, 8'h0D);
        check("b_bus_reg", Data_out, 8'h80);

        // 0x80 - 1 = 0x7F with carry and signed overflow
        G_sel = 4'b0110;
        settle();
        check("dec_ovf_tags", {4'h0, Tags}, 8'h0C);

        // 0 - 1 = 0xFF, N only
        A_sel = 2'd0;
        settle();
        check("dec_zero_tags", {4'h0, Tags}, 8'h02);

        // 5 - 3 = 2 with carry, written to R3
        A_sel = 2'd1; MB_sel = 1'b1; Cons_IN = 8'h03; G_sel = 4'b0101;
        settle();
        check("sub_tags", {4'h0, Tags}, 8'h04);
        D_sel = 2'd3; Load_en = 4'b1000;
        tick();
        Load_en = 4'b0000; A_sel = 2'd3;
        settle();
        check("sub_result", Address_out, 8'h02);

        // XOR 0x05 ^ 0x0F = 0x0A into R0
        A_sel = 2'd1; Cons_IN = 8'h0F; G_sel = 4'b1010;
        settle();
        check("xor_tags", {4'h0, Tags}, 8'h00);
        D_sel = 2'd0; Load_en = 4'b0001;
        tick();
        Load_en = 4'b0000; A_sel = 2'd0;
        settle();
        check("xor_result", Address_out, 8'h0A);

        G_sel = 4'b1111;
        settle();
        check("ones_tags", {4'h0, Tags}, 8'h02);
        Cons_IN = 8'hFF; G_sel = 4'b1101;
        settle();
        check("not_b_tags", {4'h0, Tags}, 8'h01);

        // Shifter; ALU set up to carry (0x80 + 0x81) to show C/V suppressed
        A_sel = 2'd2; MB_sel = 1'b1; Cons_IN = 8'h81; G_sel = 4'b0010; MF_sel = 1'b1;
        H_sel = 2'b01; D_sel = 2'd3; Load_en = 4'b1000;
        settle();
        check("shr_tags", {4'h0, Tags}, 8'h00);
        tick();
        Load_en = 4'b0000; A_sel = 2'd3;
        settle();
        check("shr_result", Address_out, 8'h40);

        A_sel = 2'd2; H_sel = 2'b10; Load_en = 4'b1000;
        settle();
        check("shl_tags", {4'h0, Tags}, 8'h00);
        tick();
        Load_en = 4'b0000; A_sel = 2'd3;
        settle();
        check("shl_result", Address_out, 8'h02);

        H_sel = 2'b11;
        settle();
        check("shzero_tags", {4'h0, Tags}, 8'h01);
        H_sel = 2'b00;
        settle();
        check("shpass_tags", {4'h0, Tags}, 8'h02);

        // No bypass: R3 reads old value until the edge
        MD_sel = 1'b1; Data_IN = 8'h55; D_sel = 2'd3; Load_en = 4'b1000; A_sel = 2'd3;
        settle();
        check("no_bypass_before", Address_out, 8'h02);
        tick();
        Load_en = 4'b0000;
        settle();
        check("no_bypass_after", Address_out, 8'h55);

        // Enable gating: Load_en bit for D_sel is clear
        D_sel = 2'd3; Load_en = 4'b0001; MD_sel = 1'b1; Data_IN = 8'hAA;
        tick();
        Load_en = 4'b0000;
        A_sel = 2'd0; settle(); check("gate_r0", Address_out, 8'h0A);
        A_sel = 2'd1; settle(); check("gate_r1", Address_out, 8'h05);
        A_sel = 2'd2; settle(); check("gate_r2", Address_out, 8'h80);
        A_sel = 2'd3; settle(); check("gate_r3", Address_out, 8'h55);

        // Asynchronous reset mid-cycle, with a write pending
        A_sel = 2'd1; D_sel = 2'd1; Load_en = 4'b0010; Data_IN = 8'hEE;
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_r1", Address_out, 8'h00);
        tick();
        check("reset_beats_write", Address_out, 8'h00);
        Load_en = 4'b0000; A_sel = 2'd0; B_sel = 2'd0; MB_sel = 1'b0;
        MF_sel = 1'b0; MD_sel = 1'b0; G_sel = 4'b0000;
        settle();
        check("reset2_addr", Address_out, 8'h00);
        check("reset2_tags", {4'h0, Tags}, 8'h01);
        reset = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
